// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Encoding decode treats as a harmless no-op.
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    // Opcode decode recognises as HALT (fetch only sees the halt strobe).
    localparam logic [4:0]  HALT_OPC  = 5'b00000;
    // Instruction queue depth; the buffer logic assumes exactly two entries.
    localparam int          BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // normal fetching
        S_DRAIN = 2'd1,   // swallow one in-flight response after a flush
        S_HALT  = 2'd2    // stopped until reset or an even redirect
    } fetch_state_t;

    // One queued instruction plus the PC of the following word.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_next;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry instruction queue of {instr, pc+2} between imem and decode.
// Latency: a push is visible at the head the cycle after the pushing edge.
// Backpressure: pop only while non-empty; push ignored when full without a
//   same-cycle pop; flush empties the queue and wins over push and pop.
// Ports: clk/rst_n; push + push_entry; pop; flush; head (oldest entry);
//   occupancy (0..2).
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   occupancy
);

    fetch_entry_t slots [BUF_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (occupancy != 2'd0);
    assign do_push = push && ((occupancy != 2'd2) || do_pop);
    assign head    = slots[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else if (flush) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Storage needs no reset: the head is only used while occupancy != 0.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            slots[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem read outstanding and feeds
//   decode from a 2-entry queue; handles stall, redirect and halt.
// Latency: zero-wait imem -> instr one cycle after the accepting edge,
//   one instruction per cycle sustained; redirect target valid at t+2.
// Backpressure: stall holds the head; new requests stop once queue plus
//   outstanding request would exceed two entries.
// Ports: imem_req/addr/rdata/done (memory side); stall, redirect,
//   redirect_pc, halt (pipeline control); instr, pc_next, instr_valid
//   (to decode); err (sticky odd-redirect flag).
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_done,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic [15:0] instr,
    output logic [15:0] pc_next,
    output logic        instr_valid,
    output logic        err
);
    import fetch_pkg::*;

    fetch_state_t state;
    logic [15:0]  fetch_pc;
    logic [15:0]  pend_addr;   // address of the request still waiting on imem_done
    logic [15:0]  pc_inc;
    logic         pending;
    logic         started;     // keeps imem_req low until the first edge out of reset
    logic         accept;
    logic         in_flight;   // request outstanding past this edge
    logic         buf_push;
    logic         buf_pop;
    logic         buf_flush;
    logic [1:0]   occ;
    fetch_entry_t head;
    fetch_entry_t push_entry;

    assign pc_inc    = fetch_pc + 16'd2;   // wraps FFFE -> 0000
    assign accept    = imem_req & imem_done;
    assign in_flight = imem_req & ~imem_done;

    // A pending request keeps its original address even if the PC was
    // redirected underneath it.
    assign imem_addr = pending ? pend_addr : fetch_pc;

    always_comb begin
        imem_req = 1'b0;
        if (started) begin
            case (state)
                S_FETCH: imem_req = pending ||
                                    (({1'b0, occ} + {2'b00, pending}) < 3'(BUF_DEPTH));
                default: imem_req = pending;
            endcase
        end
    end

    // Responses are kept only in normal fetch with no flush this cycle.
    assign buf_push   = accept && (state == S_FETCH) && !redirect && !halt;
    assign buf_flush  = redirect || halt;
    assign buf_pop    = instr_valid && !stall;
    assign push_entry = '{instr: imem_rdata, pc_next: pc_inc};

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (buf_push),
        .push_entry (push_entry),
        .pop        (buf_pop),
        .flush      (buf_flush),
        .head       (head),
        .occupancy  (occ)
    );

    // Decode-facing outputs come from queue head and state only.
    assign instr_valid = (state == S_FETCH) && (occ != 2'd0);
    assign instr       = instr_valid ? head.instr   : NOP_INSTR;
    assign pc_next     = instr_valid ? head.pc_next : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            fetch_pc  <= RESET_PC;
            pend_addr <= RESET_PC;
            pending   <= 1'b0;
            started   <= 1'b0;
            err       <= 1'b0;
        end else begin
            started <= 1'b1;
            pending <= in_flight;
            if (in_flight) begin
                pend_addr <= imem_addr;
            end

            if (redirect) begin
                if (redirect_pc[0]) begin
                    err   <= 1'b1;
                    state <= S_HALT;
                end else begin
                    fetch_pc <= redirect_pc;
                    // Anything still outstanding must be swallowed first.
                    state    <= in_flight ? S_DRAIN : S_FETCH;
                end
            end else begin
                case (state)
                    S_FETCH: begin
                        if (halt) begin
                            state <= S_HALT;
                        end else if (accept) begin
                            fetch_pc <= pc_inc;
                        end
                    end
                    S_DRAIN: begin
                        if (halt) begin
                            state <= S_HALT;
                        end else if (imem_done) begin
                            state <= S_FETCH;
                        end
                    end
                    S_HALT: begin
                        state <= S_HALT;
                    end
                    default: begin
                        state <= S_FETCH;
                    end
                endcase
            end
        end
    end

endmodule
